// File: rtl/ammo_launcher_pkg.sv
// Shared launcher types and screen geometry; the obstacle field uses the same bounds.
package launcher_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2,
        RELOAD   = 2'd3
    } state_t;

    // Park position sits beyond X_MAX so an idle round can never overlap an obstacle.
    localparam logic [9:0] PARK_X = 10'd1000;
    localparam logic [9:0] PARK_Y = 10'd1000;
    localparam logic [9:0] Y_MIN  = 10'd3;
    localparam logic [9:0] X_MAX  = 10'd636;

endpackage

// File: rtl/ammo_launcher_if.sv
// Player/obstacle-field side bus of the launcher: ship and key inputs, round position and status.
interface ammo_launcher_if;

    logic       fire_key;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic [9:0] ship_size;
    logic       bullet_hit;
    logic [9:0] ball_ammo_x;
    logic [9:0] ball_ammo_y;
    logic [9:0] ball_ammo_size;
    logic       ammo_active;
    logic [7:0] ammo_left;
    logic       shot_fired;
    logic       ammo_hit;

    modport slave (
        input  fire_key, ship_x, ship_y, ship_size, bullet_hit,
        output ball_ammo_x, ball_ammo_y, ball_ammo_size,
        output ammo_active, ammo_left, shot_fired, ammo_hit
    );

    modport master (
        output fire_key, ship_x, ship_y, ship_size, bullet_hit,
        input  ball_ammo_x, ball_ammo_y, ball_ammo_size,
        input  ammo_active, ammo_left, shot_fired, ammo_hit
    );

endinterface

// File: rtl/ammo_launcher_frame_countdown.sv
// 8-bit frame countdown: load wins over decrement, stops at zero, done while the value is 1.
module frame_countdown (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_done
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_done = (r_count == 8'd1);

endmodule

// File: rtl/ammo_launcher.sv
// Single-round projectile launcher: spawns above the ship on a fire edge, climbs one step
// per frame, retires on hit or top exit, then runs cooldown and magazine reload.
module ammo_launcher
    import launcher_pkg::*;
#(
    parameter int AMMO_SIZE       = 4,
    parameter int AMMO_Y_STEP     = 6,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MAG_CAPACITY    = 10,
    parameter int RELOAD_FRAMES   = 60
) (
    input  logic             frame_clk,
    input  logic             Reset,
    ammo_launcher_if.slave   bus
);

    localparam logic [9:0]  L_SIZE     = 10'(AMMO_SIZE);
    localparam logic [9:0]  L_STEP     = 10'(AMMO_Y_STEP);
    localparam logic [9:0]  L_TOP_EXIT = 10'(Y_MIN + L_STEP);
    localparam logic [7:0]  L_COOL     = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0]  L_RELOAD   = 8'(RELOAD_FRAMES);
    localparam logic [7:0]  L_MAG      = 8'(MAG_CAPACITY);

    state_t      r_state;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_active;
    logic [7:0]  r_left;
    logic        r_shot;
    logic        r_hit;
    logic        r_prev_fire;

    logic        w_fire_edge;
    logic        w_top_exit;
    logic [10:0] w_spawn_floor;
    logic [9:0]  w_launch_y;
    logic        w_cd_load;
    logic [7:0]  w_cd_val;
    logic        w_cd_done;

    assign w_fire_edge = bus.fire_key & ~r_prev_fire;
    // Compare before subtracting so the round parks instead of wrapping past zero.
    assign w_top_exit  = (r_y < L_TOP_EXIT);

    // Widened sum keeps the saturation test correct even for very large ship radii.
    assign w_spawn_floor = {1'b0, bus.ship_size} + {1'b0, Y_MIN};
    assign w_launch_y    = ({1'b0, bus.ship_y} < w_spawn_floor) ? Y_MIN
                                                                : (bus.ship_y - bus.ship_size);

    always_comb begin
        w_cd_load = 1'b0;
        w_cd_val  = L_COOL;
        case (r_state)
            FLYING: begin
                if (bus.bullet_hit || w_top_exit) begin
                    w_cd_load = 1'b1;
                end
            end
            COOLDOWN: begin
                if (w_cd_done && (r_left == 8'd0)) begin
                    w_cd_load = 1'b1;
                    w_cd_val  = L_RELOAD;
                end
            end
            default: ;
        endcase
    end

    frame_countdown u_countdown (
        .clk        (frame_clk),
        .rst        (Reset),
        .i_load     (w_cd_load),
        .i_load_val (w_cd_val),
        .o_done     (w_cd_done)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_x         <= PARK_X;
            r_y         <= PARK_Y;
            r_active    <= 1'b0;
            r_left      <= L_MAG;
            r_shot      <= 1'b0;
            r_hit       <= 1'b0;
            r_prev_fire <= 1'b1;
        end else begin
            r_prev_fire <= bus.fire_key;
            r_shot      <= 1'b0;
            r_hit       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fire_edge && (r_left != 8'd0)) begin
                        r_state  <= FLYING;
                        r_x      <= bus.ship_x;
                        r_y      <= w_launch_y;
                        r_left   <= r_left - 8'd1;
                        r_shot   <= 1'b1;
                        r_active <= 1'b1;
                    end
                end
                FLYING: begin
                    if (bus.bullet_hit || w_top_exit) begin
                        r_hit    <= bus.bullet_hit;
                        r_x      <= PARK_X;
                        r_y      <= PARK_Y;
                        r_active <= 1'b0;
                        r_state  <= COOLDOWN;
                    end else begin
                        r_y <= r_y - L_STEP;
                    end
                end
                COOLDOWN: begin
                    if (w_cd_done) begin
                        r_state <= (r_left != 8'd0) ? IDLE : RELOAD;
                    end
                end
                RELOAD: begin
                    if (w_cd_done) begin
                        r_left  <= L_MAG;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ball_ammo_x    = r_x;
    assign bus.ball_ammo_y    = r_y;
    assign bus.ball_ammo_size = L_SIZE;
    assign bus.ammo_active    = r_active;
    assign bus.ammo_left      = r_left;
    assign bus.shot_fired     = r_shot;
    assign bus.ammo_hit       = r_hit;

endmodule

// File: tb/tb_ammo_launcher.sv
// Directed bench for ammo_launcher: per-frame vector table plus flight, magazine and reset sequences.
module tb_ammo_launcher;

    localparam int P = 1000;

    logic frame_clk = 1'b0;
    logic Reset;

    always #5 frame_clk = ~frame_clk;

    ammo_launcher_if bus ();

    ammo_launcher dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    typedef struct {
        logic fire;
        logic hit;
        int   sx;
        int   sy;
        int   ss;
        int   ex;
        int   ey;
        logic ea;
        int   el;
        logic es;
        logic eh;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic f, input logic h, input int sx, input int sy, input int ss,
                       input int ex, input int ey, input logic ea, input int el,
                       input logic es, input logic eh);
        vec_t v;
        v = '{fire: f, hit: h, sx: sx, sy: sy, ss: ss, ex: ex, ey: ey,
              ea: ea, el: el, es: es, eh: eh};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset           = 1'b1;
        bus.fire_key    = 1'b1;
        bus.bullet_hit  = 1'b0;
        bus.ship_x      = 10'd320;
        bus.ship_y      = 10'd440;
        bus.ship_size   = 10'd16;
        repeat (2) @(posedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_x", int'(bus.ball_ammo_x), P);
        chk("reset_y", int'(bus.ball_ammo_y), P);
        chk("reset_active", int'(bus.ammo_active), 0);
        chk("reset_left", int'(bus.ammo_left), 10);
        chk("reset_size", int'(bus.ball_ammo_size), 4);
        chk("reset_shot", int'(bus.shot_fired), 0);

        // fire  hit  sx   sy   ss  | ex   ey   act left shot hit
        add(1, 0, 320, 440, 16,  P,   P,   0, 10, 0, 0);   // key held through reset
        add(1, 0, 320, 440, 16,  P,   P,   0, 10, 0, 0);
        add(1, 0, 320, 440, 16,  P,   P,   0, 10, 0, 0);
        add(1, 0, 320, 440, 16,  P,   P,   0, 10, 0, 0);
        add(1, 0, 320, 440, 16,  P,   P,   0, 10, 0, 0);
        add(0, 1, 320, 440, 16,  P,   P,   0, 10, 0, 0);   // hit while idle ignored
        add(1, 0, 320, 440, 16,  320, 424, 1, 9,  1, 0);   // launch
        add(1, 0, 100, 440, 16,  320, 418, 1, 9,  0, 0);   // x not steered
        add(0, 1, 100, 440, 16,  P,   P,   0, 9,  0, 1);   // hit retires, cooldown entry
        add(1, 1, 100, 440, 16,  P,   P,   0, 9,  0, 0);
        add(0, 0, 100, 440, 16,  P,   P,   0, 9,  0, 0);
        add(1, 1, 100, 440, 16,  P,   P,   0, 9,  0, 0);
        add(0, 0, 100, 440, 16,  P,   P,   0, 9,  0, 0);
        add(1, 0, 100, 440, 16,  P,   P,   0, 9,  0, 0);
        add(0, 1, 100, 440, 16,  P,   P,   0, 9,  0, 0);
        add(1, 0, 100, 440, 16,  P,   P,   0, 9,  0, 0);   // cooldown edge 7
        add(0, 0, 100, 440, 16,  P,   P,   0, 9,  0, 0);   // cooldown edge 8 -> IDLE
        add(1, 0, 200, 10,  16,  200, 3,   1, 8,  1, 0);   // spawn saturates at Y_MIN
        add(0, 1, 200, 10,  16,  P,   P,   0, 8,  0, 1);   // hit and top exit together

        foreach (vecs[i]) begin
            bus.fire_key   = vecs[i].fire;
            bus.bullet_hit = vecs[i].hit;
            bus.ship_x     = 10'(vecs[i].sx);
            bus.ship_y     = 10'(vecs[i].sy);
            bus.ship_size  = 10'(vecs[i].ss);
            tick();
            $display("vec %0d: fire=%0b hit=%0b -> x=%0d y=%0d act=%0b left=%0d shot=%0b ahit=%0b",
                     i, vecs[i].fire, vecs[i].hit, bus.ball_ammo_x, bus.ball_ammo_y,
                     bus.ammo_active, bus.ammo_left, bus.shot_fired, bus.ammo_hit);
            chk($sformatf("v%0d_x", i), int'(bus.ball_ammo_x), vecs[i].ex);
            chk($sformatf("v%0d_y", i), int'(bus.ball_ammo_y), vecs[i].ey);
            chk($sformatf("v%0d_active", i), int'(bus.ammo_active), int'(vecs[i].ea));
            chk($sformatf("v%0d_left", i), int'(bus.ammo_left), vecs[i].el);
            chk($sformatf("v%0d_shot", i), int'(bus.shot_fired), int'(vecs[i].es));
            chk($sformatf("v%0d_hit", i), int'(bus.ammo_hit), int'(vecs[i].eh));
        end

        // Full climb without hits: y reaches 4 after 70 steps, parks on the 71st edge.
        do_reset();
        bus.fire_key = 1'b0;
        tick();
        bus.fire_key = 1'b1;
        tick();
        chk("climb_launch_y", int'(bus.ball_ammo_y), 424);
        bus.fire_key = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            chk($sformatf("climb_y_%0d", k), int'(bus.ball_ammo_y), 424 - 6 * k);
        end
        $display("climb: after 70 steps y=%0d", bus.ball_ammo_y);
        tick();
        $display("climb: edge 71 y=%0d act=%0b ahit=%0b", bus.ball_ammo_y, bus.ammo_active, bus.ammo_hit);
        chk("climb_park_y", int'(bus.ball_ammo_y), P);
        chk("climb_park_active", int'(bus.ammo_active), 0);
        chk("climb_park_hit", int'(bus.ammo_hit), 0);
        repeat (8) tick();

        // Empty the magazine (9 rounds left), then cooldown and reload with fire mashed.
        for (int r = 0; r < 9; r++) begin
            bus.fire_key = 1'b1;
            tick();
            chk($sformatf("mag_r%0d_shot", r), int'(bus.shot_fired), 1);
            chk($sformatf("mag_r%0d_left", r), int'(bus.ammo_left), 8 - r);
            bus.fire_key   = 1'b0;
            bus.bullet_hit = 1'b1;
            tick();
            chk($sformatf("mag_r%0d_hit", r), int'(bus.ammo_hit), 1);
            bus.bullet_hit = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                bus.fire_key = (i % 2 == 1);
                tick();
                chk($sformatf("mag_r%0d_cd%0d_active", r, i), int'(bus.ammo_active), 0);
            end
            $display("mag: round %0d retired, left=%0d", r, bus.ammo_left);
        end
        bus.bullet_hit = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            bus.fire_key = (i % 2 == 1) && (i < 60);
            tick();
            chk($sformatf("reload_%0d_left", i), int'(bus.ammo_left), (i == 60) ? 10 : 0);
            chk($sformatf("reload_%0d_active", i), int'(bus.ammo_active), 0);
            chk($sformatf("reload_%0d_hit", i), int'(bus.ammo_hit), 0);
        end
        $display("reload: done, left=%0d", bus.ammo_left);
        bus.bullet_hit = 1'b0;
        bus.fire_key   = 1'b1;
        tick();
        chk("post_reload_shot", int'(bus.shot_fired), 1);
        chk("post_reload_left", int'(bus.ammo_left), 9);

        // Asynchronous reset mid-flight parks immediately, between clock edges.
        bus.fire_key = 1'b0;
        tick();
        #2;
        Reset = 1'b1;
        #1;
        $display("async reset: x=%0d y=%0d act=%0b left=%0d", bus.ball_ammo_x, bus.ball_ammo_y,
                 bus.ammo_active, bus.ammo_left);
        chk("areset_x", int'(bus.ball_ammo_x), P);
        chk("areset_y", int'(bus.ball_ammo_y), P);
        chk("areset_active", int'(bus.ammo_active), 0);
        chk("areset_left", int'(bus.ammo_left), 10);
        bus.fire_key = 1'b1;
        @(negedge frame_clk);
        Reset = 1'b0;
        repeat (3) tick();
        chk("held_after_reset_active", int'(bus.ammo_active), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
